updown_counter_ext: RTL and testbench

Parametrised up/down modulo counter that replaces the fixed step-of-one counter used for FIFO pointers and occupancy tracking. It adds a programmable step, synchronous clear and load, a wrap or saturate mode, and boundary flags. It sits beside the FIFO control logic and drives read/write pointers, fill levels and timeout counts. It runs in a single clock domain.

---
 rtl/updown_counter_ext.sv | 58 +++++
 tb/tb_updown_counter_ext.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/updown_counter_ext.sv
// updown_counter_ext: up/down modulo counter with programmable step, clear/load, wrap or saturate, boundary flags
module updown_counter_ext #(
  parameter int MODULUS  = 20,
  parameter int WIDTH    = $clog2(MODULUS),
  parameter bit SATURATE = 1'b0
) (
  input  logic             iCLK,
  input  logic             iRST_n,
  input  logic             iCLEAR,
  input  logic             iLOAD,
  input  logic [WIDTH-1:0] iLOAD_VAL,
  input  logic             iENABLE,
  input  logic             iUP_DOWN,
  input  logic [WIDTH-1:0] iSTEP,
  output logic [WIDTH-1:0] oCOUNT,
  output logic             oTC,
  output logic             oLOAD_ERR,
  output logic             oAT_MAX,
  output logic             oAT_MIN
);
  localparam logic [WIDTH:0] MOD = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] MAX = MOD - 1'b1;
  logic [WIDTH:0] cnt, ldVal, stepIn, step, sum, upNext, dnNext;
  logic           over, under, loadBad;
  logic [WIDTH-1:0] countNext;
  logic           tcNext, errNext;
  // all arithmetic one bit wider than the count so sums never overflow
  always_comb begin
    cnt       = {1'b0, oCOUNT};
    ldVal     = {1'b0, iLOAD_VAL};
    stepIn    = {1'b0, iSTEP};
    step      = (stepIn >= MOD) ? MAX : stepIn;
    sum       = cnt + step;
    over      = sum >= MOD;
    under     = cnt < step;
    loadBad   = ldVal >= MOD;
    upNext    = over ? (SATURATE ? MAX : sum - MOD) : sum;
    dnNext    = under ? (SATURATE ? '0 : cnt + (MOD - step)) : cnt - step;
    countNext = iCLEAR  ? '0 :
                iLOAD   ? WIDTH'(loadBad ? MAX : ldVal) :
                iENABLE ? WIDTH'(iUP_DOWN ? upNext : dnNext) : oCOUNT;
    tcNext    = !iCLEAR && !iLOAD && iENABLE && (iUP_DOWN ? over : under);
    errNext   = !iCLEAR && iLOAD && loadBad;
  end
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oCOUNT    <= '0;
      oTC       <= 1'b0;
      oLOAD_ERR <= 1'b0;
    end else begin
      oCOUNT    <= countNext;
      oTC       <= tcNext;
      oLOAD_ERR <= errNext;
    end
  end
  assign oAT_MAX = cnt == MAX;
  assign oAT_MIN = oCOUNT == '0;
endmodule

// File: tb/tb_updown_counter_ext.sv
// tb_updown_counter_ext: directed checks of wrap and saturate counter instances sharing one stimulus
module tb_updown_counter_ext;
  logic       iCLK = 1'b0, iRST_n = 1'b0, iCLEAR = 1'b0, iLOAD = 1'b0, iENABLE = 1'b0, iUP_DOWN = 1'b1;
  logic [4:0] iLOAD_VAL = '0, iSTEP = '0;
  logic [4:0] countW, countS;
  logic       tcW, errW, atMaxW, atMinW, tcS, errS, atMaxS, atMinS;
  int checks = 0, errors = 0;

  updown_counter_ext #(.MODULUS(20), .SATURATE(1'b0)) dutW (
    .iCLK(iCLK), .iRST_n(iRST_n), .iCLEAR(iCLEAR), .iLOAD(iLOAD), .iLOAD_VAL(iLOAD_VAL),
    .iENABLE(iENABLE), .iUP_DOWN(iUP_DOWN), .iSTEP(iSTEP), .oCOUNT(countW), .oTC(tcW),
    .oLOAD_ERR(errW), .oAT_MAX(atMaxW), .oAT_MIN(atMinW));
  updown_counter_ext #(.MODULUS(20), .SATURATE(1'b1)) dutS (
    .iCLK(iCLK), .iRST_n(iRST_n), .iCLEAR(iCLEAR), .iLOAD(iLOAD), .iLOAD_VAL(iLOAD_VAL),
    .iENABLE(iENABLE), .iUP_DOWN(iUP_DOWN), .iSTEP(iSTEP), .oCOUNT(countS), .oTC(tcS),
    .oLOAD_ERR(errS), .oAT_MAX(atMaxS), .oAT_MIN(atMinS));

  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge iCLK);
    #1;
  endtask

  task automatic drive(input logic clr, input logic ld, input logic [4:0] val,
                       input logic en, input logic up, input logic [4:0] st);
    iCLEAR = clr; iLOAD = ld; iLOAD_VAL = val; iENABLE = en; iUP_DOWN = up; iSTEP = st;
  endtask

  initial begin
    #2;
    check("rst_cnt", countW, 0);
    check("rst_tc", tcW, 0);
    check("rst_err", errW, 0);
    check("rst_min", atMinW, 1);
    check("rst_max", atMaxW, 0);
    check("rst_cnt_s", countS, 0);
    #11 iRST_n = 1'b1;
    drive(0, 0, 0, 1, 1, 1);
    for (int i = 1; i <= 20; i++) begin
      tick;
      check("up1_cnt", countW, i % 20);
      check("up1_tc", tcW, i == 20);
      check("sat_up1_cnt", countS, i > 19 ? 19 : i);
      check("sat_up1_tc", tcS, i == 20);
    end
    drive(0, 0, 0, 1, 0, 1);
    tick;
    check("dn1_cnt", countW, 19);
    check("dn1_tc", tcW, 1);
    check("sat_dn1_cnt", countS, 18);
    check("sat_dn1_tc", tcS, 0);
    drive(0, 1, 17, 0, 1, 0);
    tick;
    check("ld17", countW, 17);
    drive(0, 0, 0, 1, 1, 5);
    tick;
    check("up5_cnt", countW, 2);
    check("up5_tc", tcW, 1);
    drive(0, 0, 0, 1, 0, 3);
    tick;
    check("dn3_cnt", countW, 19);
    check("dn3_tc", tcW, 1);
    drive(0, 0, 0, 1, 0, 0);
    tick;
    check("dn0_cnt", countW, 19);
    check("dn0_tc", tcW, 0);
    drive(0, 1, 18, 0, 1, 0);
    tick;
    check("ld18_s", countS, 18);
    drive(0, 0, 0, 1, 1, 1);
    tick;
    check("bnd_cnt", countW, 19);
    check("bnd_tc", tcW, 0);
    check("bnd_max", atMaxW, 1);
    check("sat_a_cnt", countS, 19);
    check("sat_a_tc", tcS, 0);
    tick;
    check("sat_b_cnt", countS, 19);
    check("sat_b_tc", tcS, 1);
    tick;
    check("sat_c_cnt", countS, 19);
    check("sat_c_tc", tcS, 1);
    check("sat_c_max", atMaxS, 1);
    drive(0, 1, 2, 0, 1, 0);
    tick;
    drive(0, 0, 0, 1, 0, 4);
    tick;
    check("sat_dn4_cnt", countS, 0);
    check("sat_dn4_tc", tcS, 1);
    check("sat_dn4_min", atMinS, 1);
    check("wrap_dn4_cnt", countW, 18);
    check("wrap_dn4_tc", tcW, 1);
    drive(0, 0, 0, 1, 1, 25);
    tick;
    check("bigstep_cnt", countW, 17);
    check("bigstep_tc", tcW, 1);
    check("bigstep_cnt_s", countS, 19);
    drive(0, 0, 0, 0, 1, 0);
    tick;
    check("hold_cnt", countW, 17);
    check("hold_tc", tcW, 0);
    drive(1, 1, 7, 1, 1, 1);
    tick;
    check("pri_clr_cnt", countW, 0);
    check("pri_clr_tc", tcW, 0);
    drive(0, 1, 7, 1, 1, 1);
    tick;
    check("pri_ld_cnt", countW, 7);
    check("pri_ld_tc", tcW, 0);
    check("pri_ld_err", errW, 0);
    drive(0, 1, 25, 0, 1, 0);
    tick;
    check("ldbad_cnt", countW, 19);
    check("ldbad_err", errW, 1);
    drive(0, 0, 0, 0, 1, 0);
    tick;
    check("ldbad_idle_err", errW, 0);
    check("ldbad_idle_cnt", countW, 19);
    drive(0, 1, 31, 0, 1, 0);
    tick;
    check("ldbad2_err", errW, 1);
    #3 iRST_n = 1'b0;
    #1;
    check("arst_err", errW, 0);
    check("arst_cnt0", countW, 0);
    #1 iRST_n = 1'b1;
    drive(1, 0, 0, 0, 1, 0);
    tick;
    drive(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 11; i++) tick;
    check("cnt11", countW, 11);
    #3 iRST_n = 1'b0;
    #1;
    check("arst_cnt", countW, 0);
    check("arst_tc", tcW, 0);
    check("arst_min", atMinW, 1);
    check("arst_cnt_s", countS, 0);
    #1 iRST_n = 1'b1;
    tick;
    check("post_rst_cnt", countW, 1);
    check("post_rst_tc", tcW, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
